uart_rx: RTL and testbench

//  8N1 UART receiver; counterpart to the team's uart_tx, same BAUDRATE/SYSCLOCK scheme.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 110 +++++++++++
 tb/tb_uart_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and baud helpers
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE  = 3'd0;
  localparam uart_state_t ST_START = 3'd1;
  localparam uart_state_t ST_DATA  = 3'd2;
  localparam uart_state_t ST_STOP  = 3'd3;
  localparam uart_state_t ST_BREAK = 3'd4;

  function automatic int clocks_per_baud(input int sys, input int baud);
    return sys / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with configurable reset value
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= RESET_VAL;
      o_q  <= RESET_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, mid-bit sampling, one-cycle byte/frame-error strobes
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUDRATE = 115200,
  parameter int SYSCLOCK = 100000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  // CLOCKS_PER_BAUD below 4 leaves no usable half-bit offset and is not supported.
  localparam int CLOCKS_PER_BAUD = clocks_per_baud(SYSCLOCK, BAUDRATE);
  localparam int HALF_BAUD       = CLOCKS_PER_BAUD / 2;
  localparam int CW              = $clog2(CLOCKS_PER_BAUD) + 1;

  localparam logic [CW-1:0] FULL_LOAD = CW'(CLOCKS_PER_BAUD - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_BAUD - 1);

  logic          rx_s;
  uart_state_t   state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          sample;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_uart_rx),
    .o_q     (rx_s)
  );

  assign sample = (baud_cnt == '0);
  assign o_busy = (state != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      baud_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE:  baud_cnt <= rx_s ? '0 : HALF_LOAD;
        ST_BREAK: baud_cnt <= '0;
        default:  baud_cnt <= sample ? FULL_LOAD : baud_cnt - 1'b1;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) state <= ST_START;
        end
        ST_START: begin
          // A start bit that is high again by mid-bit was a glitch.
          if (sample) begin
            state   <= rx_s ? ST_IDLE : ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (sample) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (sample) state <= rx_s ? ST_IDLE : ST_BREAK;
        end
        ST_BREAK: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg <= '0;
    end else if (state == ST_DATA && sample) begin
      shreg <= {rx_s, shreg[7:1]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= (state == ST_STOP) && sample && rx_s;
      o_frame_err <= (state == ST_STOP) && sample && !rx_s;
      if ((state == ST_STOP) && sample && rx_s) o_data <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with randomized byte stream
module tb_uart_rx;

  localparam int SYSCLOCK = 1600000;
  localparam int BAUDRATE = 100000;
  localparam int CPB      = SYSCLOCK / BAUDRATE;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_uart_rx = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  logic [7:0] rx_q[$];
  int         rx_cyc[$];
  logic [7:0] last_good = 8'h00;

  uart_rx #(
    .BAUDRATE (BAUDRATE),
    .SYSCLOCK (SYSCLOCK)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_uart_rx   (i_uart_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_valid) begin
      rx_q.push_back(o_data);
      rx_cyc.push_back(cyc);
    end
    if (o_frame_err) fe_cnt = fe_cnt + 1;
    if (o_valid && o_frame_err) both_cnt = both_cnt + 1;
  end

  task automatic drive_bit(input logic v);
    i_uart_rx = v;
    repeat (CPB) @(negedge i_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    i_uart_rx = 1'b1;
    repeat (n * CPB) @(negedge i_clk);
  endtask

  task automatic clear_obs();
    rx_q.delete();
    rx_cyc.delete();
    fe_cnt = 0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_uart_rx = 1'b1;
    repeat (3) @(negedge i_clk);
    checks++; if (o_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", o_data); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", o_frame_err); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", o_busy); end
  endtask

  task automatic test_single();
    int t0;
    int lat;
    clear_obs();
    t0 = cyc;
    send_byte(8'hA5, 1'b1);
    idle_bits(2);
    checks++;
    if (rx_q.size() !== 1) begin
      failures++; $display("FAIL single_count got=%0d exp=1", rx_q.size());
    end else begin
      checks++; if (rx_q[0] !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", rx_q[0]); end
      lat = rx_cyc[0] - t0;
      checks++;
      if (lat < 152 || lat > 158) begin failures++; $display("FAIL single_latency got=%0d exp=152..158", lat); end
    end
    checks++; if (fe_cnt !== 0) begin failures++; $display("FAIL single_ferr got=%0d exp=0", fe_cnt); end
    checks++; if (o_data !== 8'hA5) begin failures++; $display("FAIL single_hold got=%h exp=a5", o_data); end
    last_good = 8'hA5;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[3];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h55;
    clear_obs();
    for (int i = 0; i < 3; i++) send_byte(exp[i], 1'b1);
    idle_bits(2);
    checks++;
    if (rx_q.size() !== 3) begin
      failures++; $display("FAIL b2b_count got=%0d exp=3", rx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q[i] !== exp[i]) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, rx_q[i], exp[i]); end
      end
    end
    checks++; if (fe_cnt !== 0) begin failures++; $display("FAIL b2b_ferr got=%0d exp=0", fe_cnt); end
    last_good = 8'h55;
  endtask

  task automatic test_glitch();
    clear_obs();
    i_uart_rx = 1'b0;
    repeat (4) @(negedge i_clk);
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_hi got=%b exp=1", o_busy); end
    @(negedge i_clk);
    i_uart_rx = 1'b1;
    repeat (12) @(negedge i_clk);
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_lo got=%b exp=0", o_busy); end
    idle_bits(2);
    checks++; if (rx_q.size() !== 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", rx_q.size()); end
    checks++; if (fe_cnt !== 0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", fe_cnt); end
    checks++; if (o_data !== last_good) begin failures++; $display("FAIL glitch_hold got=%h exp=%h", o_data, last_good); end
  endtask

  task automatic test_frame_error();
    clear_obs();
    send_byte(8'h3C, 1'b0);
    i_uart_rx = 1'b0;
    repeat (40 * CPB) @(negedge i_clk);
    checks++; if (fe_cnt !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", fe_cnt); end
    checks++; if (rx_q.size() !== 0) begin failures++; $display("FAIL ferr_valid got=%0d exp=0", rx_q.size()); end
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL ferr_break_busy got=%b exp=1", o_busy); end
    checks++; if (o_data !== last_good) begin failures++; $display("FAIL ferr_hold got=%h exp=%h", o_data, last_good); end
    idle_bits(2);
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL ferr_release_busy got=%b exp=0", o_busy); end
    send_byte(8'h81, 1'b1);
    idle_bits(2);
    checks++;
    if (rx_q.size() !== 1) begin
      failures++; $display("FAIL ferr_next_count got=%0d exp=1", rx_q.size());
    end else begin
      checks++; if (rx_q[0] !== 8'h81) begin failures++; $display("FAIL ferr_next_data got=%h exp=81", rx_q[0]); end
    end
    checks++; if (fe_cnt !== 1) begin failures++; $display("FAIL ferr_final_count got=%0d exp=1", fe_cnt); end
    last_good = 8'h81;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'h7E;
    clear_obs();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    i_uart_rx = b[4];
    repeat (CPB / 2) @(negedge i_clk);
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", o_busy); end
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", o_data); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", o_busy); end
    checks++; if (o_valid !== 1'b0 || o_frame_err !== 1'b0) begin
      failures++; $display("FAIL midrst_strobes got=%b%b exp=00", o_valid, o_frame_err);
    end
    i_uart_rx = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    idle_bits(2);
    send_byte(8'h7E, 1'b1);
    idle_bits(2);
    checks++;
    if (rx_q.size() !== 1) begin
      failures++; $display("FAIL midrst_next_count got=%0d exp=1", rx_q.size());
    end else begin
      checks++; if (rx_q[0] !== 8'h7E) begin failures++; $display("FAIL midrst_next_data got=%h exp=7e", rx_q[0]); end
    end
    checks++; if (fe_cnt !== 0) begin failures++; $display("FAIL midrst_ferr got=%0d exp=0", fe_cnt); end
    last_good = 8'h7E;
  endtask

  task automatic test_random_stream();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    clear_obs();
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_byte(b, 1'b1);
      if ($urandom_range(0, 3) == 0) idle_bits(1);
    end
    idle_bits(2);
    checks++;
    if (rx_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL stream_count got=%0d exp=%0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]); end
      end
    end
    checks++; if (fe_cnt !== 0) begin failures++; $display("FAIL stream_ferr got=%0d exp=0", fe_cnt); end
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL never_both got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
